// File: rtl/tbt_pkg.sv
// -----------------------------------------------------------------------------
// tbt_pkg
// Shared definitions for the 2x2 FP32 matrix multiplier and its stream wrapper.
//   WORD_W  : element width (IEEE-754 single)
//   MAT_W   : width of a packed 2x2 matrix bus
//   state_t : stream interface states
//   slot()  : element index (row-major, 0..3) to bit offset in a packed matrix
// -----------------------------------------------------------------------------
package tbt_pkg;

   localparam int WORD_W = 32;
   localparam int MAT_W  = 4 * WORD_W;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      LOAD    = 2'd1,
      WAIT    = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   // Element 0 (x00) lives in the most significant word of the packed bus.
   function automatic int slot(input logic [1:0] k);
      return (3 - int'(k)) * WORD_W;
   endfunction

endpackage

// File: rtl/tbt_word_serializer.sv
// -----------------------------------------------------------------------------
// tbt_word_serializer
// Holds a packed 2x2 result matrix and streams its four words out, r00 first,
// with a valid/ready handshake.
//   clk, reset : clock, synchronous active-high reset
//   i_load     : capture i_mat and start streaming
//   i_mat      : packed {r00,r01,r10,r11}
//   i_ready    : downstream accepts the current word
//   o_valid    : o_data holds a valid word
//   o_data     : current result word
//   o_last     : current word is r11
//   o_done     : the r11 transfer happens this cycle
// -----------------------------------------------------------------------------
module tbt_word_serializer
   import tbt_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic [MAT_W-1:0]  i_mat,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [WORD_W-1:0] o_data,
   output logic              o_last,
   output logic              o_done
);

   logic [MAT_W-1:0] r_mat;
   logic [1:0]       r_idx;
   logic             r_valid;
   logic             w_xfer;

   assign w_xfer = r_valid && i_ready;

   // Load a fresh matrix, then step the word index only on accepted
   // transfers so the current word is held while downstream stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mat   <= '0;
         r_idx   <= 2'd0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_mat   <= i_mat;
         r_idx   <= 2'd0;
         r_valid <= 1'b1;
      end else if (w_xfer) begin
         if (r_idx == 2'd3) begin
            r_valid <= 1'b0;
            r_idx   <= 2'd0;
         end else begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_mat[slot(r_idx) +: WORD_W];
   assign o_last  = r_valid && (r_idx == 2'd3);
   assign o_done  = w_xfer && (r_idx == 2'd3);

endmodule

// File: rtl/tbt_mult_stream_if.sv
// -----------------------------------------------------------------------------
// tbt_mult_stream_if
// Streaming front/back end for tbt_mult_async. Collects eight operand words
// (A then B, row-major), pulses mul_load, waits for the result, acknowledges
// it and streams the four result words out.
//   clk, reset       : clock, synchronous active-high reset
//   in_valid/ready   : operand word handshake, in_data a00..a11,b00..b11
//   mul_load         : one-cycle start pulse
//   mul_A, mul_B     : packed operand matrices, x00 in the top word
//   mul_result       : packed result matrix
//   mul_result_ready : result valid (level) until acknowledged
//   mul_result_ack   : one-cycle acknowledge
//   out_valid/ready  : result word handshake, out_data r00..r11, out_last on r11
//   busy             : transaction in progress
//   err_timeout      : sticky multiplier timeout flag
// -----------------------------------------------------------------------------
module tbt_mult_stream_if
   import tbt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              mul_load,
   output logic [MAT_W-1:0]  mul_A,
   output logic [MAT_W-1:0]  mul_B,
   input  logic [MAT_W-1:0]  mul_result,
   input  logic              mul_result_ready,
   output logic              mul_result_ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              err_timeout
);

   localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);

   state_t           r_state;
   state_t           w_nextState;
   logic [2:0]       r_wordCnt;
   logic [MAT_W-1:0] r_matA;
   logic [MAT_W-1:0] r_matB;
   logic [TMO_W-1:0] r_tmoCnt;
   logic             r_err;
   logic             r_ack;
   logic             w_accept;
   logic             w_loadSer;
   logic             w_timeout;
   logic             w_serDone;

   // Next-state decode. A ready result and a timeout in the same WAIT cycle
   // resolve in favour of the result.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_loadSer   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         COLLECT: begin
            w_accept = in_valid;
            if (in_valid && (r_wordCnt == 3'd7)) begin
               w_nextState = LOAD;
            end
         end
         LOAD: begin
            w_nextState = WAIT;
         end
         WAIT: begin
            if (mul_result_ready) begin
               w_loadSer   = 1'b1;
               w_nextState = DRAIN;
            end else if (TMO_EN && (r_tmoCnt == TMO_LAST)) begin
               w_timeout   = 1'b1;
               w_nextState = COLLECT;
            end
         end
         DRAIN: begin
            if (w_serDone) begin
               w_nextState = COLLECT;
            end
         end
         default: begin
            w_nextState = COLLECT;
         end
      endcase
   end

   // State, operand packing, timeout counter and the registered ack, which
   // lines up with the first valid result word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= COLLECT;
         r_wordCnt <= 3'd0;
         r_matA    <= '0;
         r_matB    <= '0;
         r_tmoCnt  <= '0;
         r_err     <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_ack   <= w_loadSer;
         if (w_accept) begin
            if (!r_wordCnt[2]) begin
               r_matA[slot(r_wordCnt[1:0]) +: WORD_W] <= in_data;
            end else begin
               r_matB[slot(r_wordCnt[1:0]) +: WORD_W] <= in_data;
            end
            r_wordCnt <= r_wordCnt + 3'd1;
         end
         if (w_timeout) begin
            r_err     <= 1'b1;
            r_wordCnt <= 3'd0;
         end
         if (r_state == WAIT) begin
            r_tmoCnt <= r_tmoCnt + 1'b1;
         end else begin
            r_tmoCnt <= '0;
         end
      end
   end

   tbt_word_serializer uSerializer (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_loadSer),
      .i_mat   (mul_result),
      .i_ready (out_ready),
      .o_valid (out_valid),
      .o_data  (out_data),
      .o_last  (out_last),
      .o_done  (w_serDone)
   );

   assign in_ready       = (r_state == COLLECT);
   assign mul_load       = (r_state == LOAD);
   assign mul_A          = r_matA;
   assign mul_B          = r_matB;
   assign mul_result_ack = r_ack;
   assign busy           = (r_state != COLLECT) || (r_wordCnt != 3'd0);
   assign err_timeout    = r_err;

endmodule

// File: tb/tb_tbt_mult_stream_if.sv
// -----------------------------------------------------------------------------
// tb_tbt_mult_stream_if
// Self-checking bench for tbt_mult_stream_if. The bench plays host, multiplier
// and downstream sink; expected values come from the vector table and a small
// reference model (packed matrix = row-major concatenation, output stream =
// result words in order, sticky timeout flag).
// -----------------------------------------------------------------------------
module tb_tbt_mult_stream_if;
   import tbt_pkg::*;

   localparam int TMO = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [WORD_W-1:0]  in_data;
   logic               mul_load;
   logic [MAT_W-1:0]   mul_A;
   logic [MAT_W-1:0]   mul_B;
   logic [MAT_W-1:0]   mul_result;
   logic               mul_result_ready;
   logic               mul_result_ack;
   logic               out_valid;
   logic               out_ready;
   logic [WORD_W-1:0]  out_data;
   logic               out_last;
   logic               busy;
   logic               err_timeout;

   typedef struct {
      logic [31:0]  w[8];
      logic [31:0]  r[4];
      logic [127:0] expA;
      logic [127:0] expB;
      bit           gaps;
      int           stallWord;
      int           stallLen;
      int           respDelay;
   } vec_t;

   vec_t vecs[6];
   int   nTests = 0;
   int   nFail  = 0;
   bit   expErr = 1'b0;

   // Free-running clock
   always #5 clk = ~clk;

   tbt_mult_stream_if #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .mul_load         (mul_load),
      .mul_A            (mul_A),
      .mul_B            (mul_B),
      .mul_result       (mul_result),
      .mul_result_ready (mul_result_ready),
      .mul_result_ack   (mul_result_ack),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_last         (out_last),
      .busy             (busy),
      .err_timeout      (err_timeout)
   );

   // Reference packing: row-major elements, element 0 in the top word
   function automatic logic [127:0] packMat(input logic [31:0] e0, input logic [31:0] e1,
                                            input logic [31:0] e2, input logic [31:0] e3);
      return {e0, e1, e2, e3};
   endfunction

   // Random word with a bias towards special FP32 encodings
   function automatic logic [31:0] randWord();
      case ($urandom_range(0, 7))
         0:       return 32'h7F80_0000;
         1:       return 32'h7FC0_0001;
         2:       return 32'h0000_0001;
         3:       return 32'h8000_0000;
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkReset();
      checkOutput("rst_in_ready",  in_ready, 1);
      checkOutput("rst_mul_load",  mul_load, 0);
      checkOutput("rst_ack",       mul_result_ack, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_last",  out_last, 0);
      checkOutput("rst_busy",      busy, 0);
      checkOutput("rst_err",       err_timeout, 0);
      checkOutput("rst_mul_A",     mul_A, 0);
      checkOutput("rst_mul_B",     mul_B, 0);
      checkOutput("rst_out_data",  out_data, 0);
   endtask

   task automatic resetDut();
      reset            = 1'b1;
      in_valid         = 1'b0;
      out_ready        = 1'b0;
      mul_result_ready = 1'b0;
      @(negedge clk);
      checkReset();
      reset  = 1'b0;
      expErr = 1'b0;
   endtask

   // One full transaction; abortIn < 8 resets after that many input words,
   // abortOut < 4 resets after that many output words.
   task automatic applyStimulus(input vec_t v, input int abortIn, input int abortOut);
      int k;
      int cyc;
      int j;
      int stallCnt;
      bit acc;
      bit rdy;
      k   = 0;
      cyc = 0;
      while (k < 8 && k < abortIn && cyc < 200) begin
         in_valid = v.gaps ? ((cyc % 2) == 0) : 1'b1;
         in_data  = v.w[k];
         acc      = in_valid && in_ready;
         @(negedge clk);
         if (acc) k++;
         cyc++;
      end
      in_valid = 1'b0;
      if (abortIn < 8) begin
         checkOutput("words_before_abort", k, abortIn);
         checkOutput("busy_mid_collect", busy, 1);
         resetDut();
         return;
      end
      checkOutput("words_consumed", k, 8);

      // LOAD cycle: present a junk word that must not be consumed
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      checkOutput("mul_load_high", mul_load, 1);
      checkOutput("in_ready_load", in_ready, 0);
      checkOutput("mul_A", mul_A, v.expA);
      checkOutput("mul_B", mul_B, v.expB);
      checkOutput("busy_load", busy, 1);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("mul_load_single", mul_load, 0);
      checkOutput("mul_A_held", mul_A, v.expA);
      checkOutput("mul_B_held", mul_B, v.expB);

      // WAIT: multiplier response after respDelay cycles, or never
      for (int c = 0; c < v.respDelay && c < TMO; c++) begin
         checkOutput("no_ack_wait", mul_result_ack, 0);
         checkOutput("err_wait", err_timeout, expErr);
         checkOutput("no_out_wait", out_valid, 0);
         @(negedge clk);
      end
      if (v.respDelay >= TMO) begin
         expErr = 1'b1;
         checkOutput("err_timeout_set", err_timeout, 1);
         checkOutput("in_ready_after_tmo", in_ready, 1);
         checkOutput("no_ack_tmo", mul_result_ack, 0);
         checkOutput("busy_after_tmo", busy, 0);
         return;
      end
      mul_result       = packMat(v.r[0], v.r[1], v.r[2], v.r[3]);
      mul_result_ready = 1'b1;
      @(negedge clk);
      checkOutput("ack_pulse", mul_result_ack, 1);
      checkOutput("err_after_result", err_timeout, expErr);
      mul_result_ready = 1'b0;
      mul_result       = ~mul_result;

      // DRAIN with optional backpressure on one word
      j        = 0;
      stallCnt = 0;
      cyc      = 0;
      while (j < 4 && j < abortOut && cyc < 100) begin
         checkOutput("out_valid", out_valid, 1);
         checkOutput("out_data", out_data, v.r[j]);
         checkOutput("out_last", out_last, (j == 3));
         checkOutput("in_ready_drain", in_ready, 0);
         if (cyc == 1) checkOutput("ack_single", mul_result_ack, 0);
         rdy = !(j == v.stallWord && stallCnt < v.stallLen);
         if (!rdy) stallCnt++;
         out_ready = rdy;
         @(negedge clk);
         if (rdy) j++;
         cyc++;
      end
      out_ready = 1'b0;
      if (abortOut < 4) begin
         checkOutput("words_before_abort", j, abortOut);
         resetDut();
         return;
      end
      checkOutput("words_drained", j, 4);
      checkOutput("out_valid_clear", out_valid, 0);
      checkOutput("in_ready_after", in_ready, 1);
      checkOutput("busy_after", busy, 0);
      checkOutput("ack_after", mul_result_ack, 0);
      checkOutput("err_after", err_timeout, expErr);
   endtask

   // Main sequence: table vectors, reset corner cases, then random traffic
   initial begin
      vec_t rv;
      reset            = 1'b1;
      in_valid         = 1'b0;
      in_data          = '0;
      mul_result       = '0;
      mul_result_ready = 1'b0;
      out_ready        = 1'b0;

      vecs[0].w    = '{32'h40BAE148, 32'h41028F5C, 32'hC040A3D7, 32'hC1200000,
                       32'h41A73333, 32'hC14CCCCD, 32'h4115999A, 32'h40000000};
      vecs[0].r    = '{32'h43465A1D, 32'hC269BA5E, 32'hC31C68B4, 32'h41943958};
      vecs[0].expA = 128'h40BAE148_41028F5C_C040A3D7_C1200000;
      vecs[0].expB = 128'h41A73333_C14CCCCD_4115999A_40000000;
      vecs[0].gaps = 1'b0; vecs[0].stallWord = 0; vecs[0].stallLen = 0; vecs[0].respDelay = 3;
      for (int i = 1; i < 6; i++) vecs[i] = vecs[0];
      vecs[1].gaps      = 1'b1; vecs[1].respDelay = 0;
      vecs[2].stallWord = 1;    vecs[2].stallLen  = 5;
      vecs[3].respDelay = TMO - 1;
      vecs[4].respDelay = TMO;
      vecs[5].respDelay = 5;    vecs[5].stallWord = 3; vecs[5].stallLen = 2;

      repeat (2) @(negedge clk);
      checkReset();
      reset = 1'b0;
      $display("[TB] table vectors");
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 8, 4);

      $display("[TB] reset mid-collect and mid-drain");
      applyStimulus(vecs[0], 5, 4);
      applyStimulus(vecs[0], 8, 4);
      applyStimulus(vecs[2], 8, 2);
      applyStimulus(vecs[1], 8, 4);

      $display("[TB] random transactions");
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 8; i++) rv.w[i] = randWord();
         for (int i = 0; i < 4; i++) rv.r[i] = randWord();
         rv.expA      = packMat(rv.w[0], rv.w[1], rv.w[2], rv.w[3]);
         rv.expB      = packMat(rv.w[4], rv.w[5], rv.w[6], rv.w[7]);
         rv.gaps      = ($urandom_range(0, 1) == 1);
         rv.stallWord = $urandom_range(0, 3);
         rv.stallLen  = $urandom_range(0, 4);
         rv.respDelay = $urandom_range(0, 12);
         applyStimulus(rv, 8, 4);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
